// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store initiator issuing full-word RAM accesses with local lane extract and RMW
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_*             request channel: valid/ready handshake, wen, size, unsigned, byte addr, right-aligned wdata
//   resp_*            one-cycle completion pulse with extended load data and misalignment error
//   mem_valid/rlen/raddr/rdata   word read port (rdata combinational)
//   mem_wen/waddr/wdata          word write port (commits at the next posedge)
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests skip the RAM and respond with resp_err=1
//   undefined - resp_err stays 0 and the offending low address bits are cleared before the access

module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [31:0]       mem_rlen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_RMW_RD,
    S_ST,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Request fields captured on the accept edge
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  // Results: extended load data, and the full word to be written
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged_q;

  // Request decode in IDLE
  logic              req_is_word;
  logic              trap_in;
  logic [ADDR_W-1:0] addr_in;

  // Datapath combinational results
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merge_word;
  logic [ADDR_W-1:0] word_addr;

  // FSM-decoded strobes before reset gating
  logic ready_c;
  logic rd_c;
  logic wr_c;
  logic resp_c;

  // Size 3 is handled exactly like a word
  assign req_is_word = req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_in;

  assign misalign_in = ((req_size == 2'd1) & req_addr[0]) |
                       (req_is_word & (req_addr[1:0] != 2'b00));
  assign trap_in     = misalign_in;
  assign addr_in     = req_addr;
`else
  // Without trapping, a misaligned half/word is pulled down to its natural
  // boundary and then proceeds as an ordinary aligned access.
  assign trap_in = 1'b0;
  always_comb begin
    addr_in = req_addr;
    if (req_is_word) begin
      addr_in[1:0] = 2'b00;
    end else if (req_size == 2'd1) begin
      addr_in[0] = 1'b0;
    end
  end
`endif

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Lane selection from the returned word and the read-modify-write merge
  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_ext   = mem_rdata;
    merge_word = mem_rdata;
    case (size_q)
      2'd0: begin
        load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
        case (addr_q[1:0])
          2'd0:    merge_word[7:0]   = wdata_q[7:0];
          2'd1:    merge_word[15:8]  = wdata_q[7:0];
          2'd2:    merge_word[23:16] = wdata_q[7:0];
          default: merge_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'd1: begin
        load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
        if (addr_q[1]) begin
          merge_word[31:16] = wdata_q[15:0];
        end else begin
          merge_word[15:0] = wdata_q[15:0];
        end
      end
      default: begin
        load_ext   = mem_rdata;
        merge_word = mem_rdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded strobes
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    resp_c    = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (req_valid) begin
          if (trap_in) begin
            state_nxt = S_RESP;
          end else if (!req_wen) begin
            state_nxt = S_LD;
          end else if (req_is_word) begin
            state_nxt = S_ST;
          end else begin
            state_nxt = S_RMW_RD;
          end
        end
      end
      S_LD: begin
        rd_c      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RMW_RD: begin
        rd_c      = 1'b1;
        state_nxt = S_ST;
      end
      S_ST: begin
        wr_c      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= addr_in;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            err_q    <= trap_in;
            rdata_q  <= '0;
            // A word store writes the request data untouched; subword
            // stores overwrite this in RMW_RD with the merged word.
            merged_q <= req_wdata;
          end
        end
        S_LD: begin
          rdata_q <= load_ext;
        end
        S_RMW_RD: begin
          merged_q <= merge_word;
        end
        default: begin
        end
      endcase
    end
  end

  // Gating with rst drops a pending write the instant reset rises, even
  // before the asynchronous state reset has propagated.
  assign req_ready  = ready_c & ~rst;
  assign mem_valid  = rd_c & ~rst;
  assign mem_wen    = wr_c & ~rst;
  assign resp_valid = resp_c & ~rst;

  assign mem_rlen   = mem_valid ? 32'd4 : 32'd0;
  assign mem_raddr  = mem_valid ? word_addr : '0;
  assign mem_waddr  = mem_wen ? word_addr : '0;
  assign mem_wdata  = mem_wen ? merged_q : '0;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a word-array RAM and reference model

module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_rlen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_valid    (mem_valid),
    .mem_wen      (mem_wen),
    .mem_rlen     (mem_rlen),
    .mem_raddr    (mem_raddr),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: 64 words, combinational read; writes to addresses with bit 28 are ignored
  logic [31:0] ram [0:63];
  assign mem_rdata = ram[mem_raddr[7:2]];
  always @(posedge clk) begin
    if (mem_wen && !mem_waddr[28]) ram[mem_waddr[7:2]] <= mem_wdata;
  end

  // Reference memory image as the specification says it should evolve
  logic [31:0] ref_mem [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];

  int checks = 0;
  int errors = 0;
  int exp_reads = 0;
  int obs_reads = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predict the response (and any RAM write) of a request accepted at the coming edge
  task automatic predict(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    int unsigned nb;
    int unsigned sh;
    int unsigned idx;
    logic [31:0] mask;
    logic [31:0] aa;
    logic [31:0] v;
    logic [31:0] nw;
    resp_t r;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mask = (nb == 1) ? 32'h0000_00FF : (nb == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    r.rdata = 32'd0;
    r.err   = 1'b0;
    if (TRAP && (a % nb) != 0) begin
      r.err = 1'b1;
      r.cyc = cyc + 1;
    end else begin
      aa  = a - (a % nb);
      idx = (aa >> 2) & 63;
      sh  = (aa % 4) * 8;
      exp_reads += (!w || nb < 4) ? 1 : 0;
      if (!w) begin
        v = (ref_mem[idx] >> sh) & mask;
        if (!u && nb < 4 && v[nb*8-1]) v = v | ~mask;
        r.rdata = v;
        r.cyc   = cyc + 2;
      end else begin
        if (nb == 4) begin
          nw    = d;
          r.cyc = cyc + 2;
        end else begin
          nw    = (ref_mem[idx] & ~(mask << sh)) | ((d & mask) << sh);
          r.cyc = cyc + 3;
        end
        wq.push_back('{aa & 32'hFFFF_FFFC, nw});
        if (!aa[28]) ref_mem[idx] = nw;
      end
    end
    rq.push_back(r);
  endtask

  // Present a request at a negedge and hold it until the DUT will take it
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = d;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", {31'd0, req_ready}, 32'd1);
    if (req_ready) predict(w, sz, u, a, d);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", rq.size() + wq.size(), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: every negedge, compare whatever the DUT presents against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid || mem_wen) chk("rd_wr_exclusive", {31'd0, mem_valid & mem_wen}, 32'd0);
      if (mem_valid) begin
        obs_reads++;
        chk("mem_rlen_active", mem_rlen, 32'd4);
        chk("mem_raddr_aligned", {30'd0, mem_raddr[1:0]}, 32'd0);
      end else begin
        chk("mem_rlen_idle", mem_rlen, 32'd0);
      end
      if (mem_wen) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {31'd0, mem_wen}, 32'd0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("mem_waddr", mem_waddr, e.addr);
          chk("mem_wdata", mem_wdata, e.data);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          resp_t e;
          e = rq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("resp_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] old30;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ram[i] <= v;
      ref_mem[i] = v;
    end

    // Reset state
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_rlen", mem_rlen, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Word store then load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF); idle();
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);        idle();
    drain();

    // Byte load extension on 0x80FF7F01
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01); idle();
    issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);        idle();
    issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);        idle();
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);        idle();
    drain();

    // Half store read-modify-write
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344); idle();
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD); idle();
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);        idle();
    drain();

    // Misaligned word load
    issue(1'b0, 2'd2, 1'b0, 32'h21, 32'h0);        idle();
    drain();

    // Reset during ST: the write must never reach the RAM
    old30 = ref_mem[12];
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = ~old30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("st_mem_wen", {31'd0, mem_wen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_mid_reset", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);        idle();
    drain();
    chk("word_unchanged", ram[12], old30);

    // Back-to-back: req_valid held across four queued loads
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    idle();
    drain();

    // Randomized mix, including size 3, misalignment and bit-28 addresses
    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = a | 32'h1000_0000;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    idle();
    drain();

    chk("read_accesses", obs_reads, exp_reads);
    for (int i = 0; i < 64; i++) chk("ram_image", ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the core's memory stage and the data RAM port.
- Accepts one load or store request at a time and always issues full-word accesses to the RAM, since the RAM ignores byte offset on reads and writes whole words.
- For loads, extracts and sign- or zero-extends the byte/half lane locally.
- For byte and half stores, performs a read-modify-write.

Parameters:
- ADDR_W, 32, request and RAM address width.
- DATA_W, 32, data width (only 32 supported).

Ports:
- clk input 1: clock.
- rst input 1: asynchronous active-high reset.
- req_valid input 1: request present.
- req_ready output 1: block can accept a request.
- req_wen input 1: 1=store, 0=load.
- req_size input 2: 0=byte, 1=half, 2=word, 3=treated as word.
- req_unsigned input 1: load zero-extends when 1, sign-extends when 0.
- req_addr input 32: byte address.
- req_wdata input 32: store data, right-aligned.
- resp_valid output 1: one-cycle completion pulse.
- resp_rdata output 32: extended load data (0 for stores).
- resp_err output 1: misaligned request, valid with resp_valid.
- mem_valid output 1: RAM read enable.
- mem_wen output 1: RAM write enable.
- mem_rlen output 32: read length; 32'd4 when mem_valid, else 0.
- mem_raddr output 32: word-aligned read address.
- mem_waddr output 32: word-aligned write address.
- mem_wdata output 32: full word to write.
- mem_rdata input 32: combinational RAM read data.

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - rst forces state IDLE.
  - All mem_* outputs are 0; resp_valid, resp_rdata and resp_err are 0.
  - Internal latches are cleared.
  - req_ready = (state==IDLE) & ~rst.
- States: IDLE, LD, RMW_RD, ST, RESP.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid & req_ready. On it, latch addr, size, wen, unsigned and wdata.
  - Next state: misaligned → RESP(err); load → LD; word store → ST; byte/half store → RMW_RD.
- LD:
  - mem_valid=1, mem_raddr={addr[31:2],2'b00}.
  - Register the lane: byte at addr[1:0]*8, half at addr[1]*16, extended per req_unsigned.
  - Next state: RESP.
- RMW_RD:
  - mem_valid=1, same word address.
  - Register the merged word: mem_rdata with the target lane replaced by the low byte/half of wdata.
  - Next state: ST.
- ST:
  - mem_wen=1, mem_waddr=word address, mem_wdata=merged word (or wdata for a word store).
  - The RAM commits at the next posedge.
  - Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request may be accepted the cycle after RESP.
- Latency, from the accept edge to the resp_valid cycle:
  - Load: 2.
  - Word store: 2.
  - Byte/half store: 3.
  - Misaligned: 1.
- Misaligned cases: half with addr[0]=1; word with addr[1:0]!=0. These issue no RAM access; resp_err=1, resp_rdata=0.
- mem_valid and mem_wen are never both 1 in the same cycle.
- Only one outstanding request.
- req_* inputs are ignored outside IDLE.
- Reset asserted during ST deasserts mem_wen immediately; a write not yet clocked is dropped.
- Addresses with bit 28 set are passed through unchanged; the RAM ignores those writes and the LSU does not special-case them.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misalignment is detected and reported via resp_err as above.
- Undefined:
  - resp_err is tied 0.
  - addr[0] is forced 0 for halves, and addr[1:0] is forced 0 for words.
  - The access proceeds normally with normal latency.

Test Plan:
- Word store then load:
  - Stimulus: store addr 0x10, data 0xDEADBEEF; then load word from 0x10.
  - Response: mem_wen pulses with mem_waddr=0x10; load resp_rdata=0xDEADBEEF, 2 cycles after accept.
- Byte load extension (word 0x10 = 0x80FF7F01):
  - Stimulus: load byte at 0x12, signed; then the same load unsigned.
  - Response: signed → 0xFFFFFFFF... lane is 0xFF; unsigned → 0x000000FF.
  - Stimulus: signed byte load at 0x13.
  - Response: 0xFFFFFF80.
- Half store read-modify-write:
  - Stimulus: word 0x20 = 0x11223344; store half 0xABCD at 0x22.
  - Response: RMW_RD read, then mem_wdata=0xABCD3344; resp_valid 3 cycles after accept; a following load word returns 0xABCD3344.
- Misaligned access (macro defined):
  - Stimulus: load word at 0x21.
  - Response: resp_err=1 after 1 cycle, no mem_valid or mem_wen.
  - Macro undefined: the same request reads 0x20 and resp_err=0.
- Reset mid-store:
  - Stimulus: assert rst during ST.
  - Response: mem_wen drops asynchronously; a later load shows the word unchanged; req_ready=1 after release.
- Back-to-back requests:
  - Stimulus: req_valid held high with 4 queued loads.
  - Response: each is accepted only in IDLE; exactly 4 resp_valid pulses in order; mem_rlen=4 whenever mem_valid.
